axi4lite_sram_slave: RTL and testbench
======================================

# axi4lite_sram_slave

Synthesizable AXI4-Lite slave that serves the `picorv32_axi` master port. It provides byte-writable on-chip SRAM in the low address window and a write-only console register at `CONSOLE_ADDR`. Any other address gets an SLVERR response. Read and write channels run independently, so the CPU core and a bus bench can talk to real RTL memory instead of a behavioural model.

## Interface
Parameters:
- `MEM_WORDS`, default 16384: SRAM depth in 32-bit words. Valid byte window is 0 .. 4*MEM_WORDS-1.
- `CONSOLE_ADDR`, default 32'h1000_0000: byte address of the console register.
- `INIT_FILE`, default "": hex image loaded with `$readmemh` at elaboration when non-empty.

Ports:
- `clk`, in, 1: clock, rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `mem_axi_awvalid` / `mem_axi_awready`, in/out, 1/1: write-address handshake.
- `mem_axi_awaddr`, in, 32: write byte address.
- `mem_axi_awprot`, in, 3: ignored.
- `mem_axi_wvalid` / `mem_axi_wready`, in/out, 1/1: write-data handshake.
- `mem_axi_wdata` / `mem_axi_wstrb`, in, 32/4: write data and byte strobes.
- `mem_axi_bvalid` / `mem_axi_bready`, out/in, 1/1: write-response handshake.
- `mem_axi_bresp`, out, 2: 2'b00 OKAY, 2'b10 SLVERR.
- `mem_axi_arvalid` / `mem_axi_arready`, in/out, 1/1: read-address handshake.
- `mem_axi_araddr`, in, 32: read byte address.
- `mem_axi_arprot`, in, 3: ignored.
- `mem_axi_rvalid` / `mem_axi_rready`, out/in, 1/1: read-data handshake.
- `mem_axi_rdata` / `mem_axi_rresp`, out, 32/2: read data and response.
- `console_valid`, out, 1: one-cycle pulse for each console write.
- `console_data`, out, 8: `wdata[7:0]` of that console write.

## Operation
- Address decode: word index is `addr[31:2]`; `addr[1:0]` is ignored. An address is RAM if `addr < 4*MEM_WORDS`, console if `addr[31:2] == CONSOLE_ADDR[31:2]`, otherwise error.

Read FSM (R_IDLE, R_RESP):
- `arready = resetn && state==R_IDLE`.
- Handshake in R_IDLE: the SRAM word is read synchronously at that edge and the FSM moves to R_RESP with `rvalid=1`.
- `rresp` is OKAY for RAM. For console or error addresses, `rdata=0` and `rresp=SLVERR`.
- In R_RESP, `rdata` and `rresp` are held stable until `rvalid && rready`, then the FSM returns to R_IDLE.

Write path:
- AW and W are latched independently into `aw_held` and `w_held`, in either order.
- `awready = resetn && !aw_held && !bvalid`; `wready = resetn && !w_held && !bvalid`.
- Commit happens at the first edge where an address and data are both available, each either already held or handshaking on that edge.
- RAM commit writes each byte lane whose `wstrb` bit is set, returns `bresp=OKAY`, and leaves other lanes untouched.
- Console commit pulses `console_valid` for the cycle after the edge, presents `console_data`, and returns OKAY. `wstrb` is ignored.
- Error commit leaves memory unchanged and returns SLVERR.
- Every commit sets `bvalid=1` and clears both held flags. `bvalid` stays high until `bready`; no new AW/W is accepted while `bvalid` is high.

Boundary cases:
- A read and a write to the same word at the same edge: the read returns pre-write data.
- AW and W handshaking at the same edge commit at that edge.
- `wstrb=0` to RAM returns OKAY and writes nothing.
- Reset mid-transaction: held flags, FSM state, `bvalid`, `rvalid` and `console_valid` all clear. SRAM contents are preserved.

## Timing
- Reset values while `resetn` is low: all ready/valid outputs 0, `bresp=rresp=0`, `rdata=0`, `console_valid=0`, `console_data=0`. Ready signals rise in the first cycle with `resetn` high.
- Read latency: AR handshake at edge N gives `rvalid` high from edge N to N+1. Sustained throughput is one read per 2 cycles with `rready` tied high.
- Write latency: commit at edge N gives `bvalid` high from edge N to N+1. Best-case throughput is one write per 2 cycles.
- No combinational path from any `*valid` input to any `*ready` output.

## Test plan
- Write 0xDEADBEEF with `wstrb=4'hF` to 0x100, then read 0x100: `bresp=00`, `rdata=0xDEADBEEF`, `rresp=00`, `rvalid` one cycle after AR.
- Byte write 0x000000AA with `wstrb=4'b0001` to 0x100 (holding 0xDEADBEEF): read returns 0xDEADBEAA.
- W presented 3 cycles before AW, `bready` held low 4 cycles: W latched alone, no `bvalid` until AW, `bvalid` and `bresp` stable while stalled, `awready=wready=0` during the stall.
- Write 0x41 to 0x1000_0000: `console_valid` for exactly 1 cycle with `console_data=0x41`, `bresp=00`, RAM unchanged.
- Write to 0x0002_0000 and read from 0x2000_0000: `bresp=10`, `rresp=10`, `rdata=0`, RAM unchanged.
- `resetn` low while `rvalid` high and AW held: `rvalid`, `bvalid` and held flags clear. A subsequent read of a previously written word still returns its value.

Source files
------------

// File: rtl/axi4lite_sram_slave.sv
// axi4lite_sram_slave
//   AXI4-Lite slave for the picorv32_axi master port. It serves three targets:
//   - byte-writable on-chip SRAM at byte addresses 0 .. 4*MEM_WORDS-1
//   - a write-only console register at CONSOLE_ADDR
//   - an SLVERR response for every other address
//   The read and write channels run independently of each other.
// Ports
//   clk, resetn          : clock (rising edge) and synchronous active-low reset
//   mem_axi_aw*          : write-address channel (awprot is ignored)
//   mem_axi_w*           : write-data channel with byte strobes
//   mem_axi_b*           : write-response channel (bresp 00 OKAY, 10 SLVERR)
//   mem_axi_ar*          : read-address channel (arprot is ignored)
//   mem_axi_r*           : read-data channel
//   console_valid/_data  : one-cycle pulse carrying wdata[7:0] of a console write
module axi4lite_sram_slave #(
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter              INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp,
  output logic        console_valid,
  output logic [7:0]  console_data
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES   = 33'(MEM_WORDS) << 2;
  localparam logic [0:0]  R_IDLE      = 1'b0;
  localparam logic [0:0]  R_RESP      = 1'b1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // The compare is done at 33 bits so a full 4 GiB window cannot overflow.
  function automatic logic is_ram(input logic [31:0] a);
    return {1'b0, a} < RAM_BYTES;
  endfunction

  function automatic logic is_console(input logic [31:0] a);
    return a[31:2] == CONSOLE_ADDR[31:2];
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  logic unused_prot;
  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

  // ---------------- read channel ----------------
  logic [0:0]  r_state_q, r_state_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        ar_hs;

  assign mem_axi_arready = resetn && (r_state_q == R_IDLE);
  assign ar_hs           = mem_axi_arvalid && mem_axi_arready;
  assign mem_axi_rvalid  = (r_state_q == R_RESP);
  assign mem_axi_rdata   = rdata_q;
  assign mem_axi_rresp   = rresp_q;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      default: if (mem_axi_rready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        // Console is write-only, so a console read falls into the error case.
        if (is_ram(mem_axi_araddr)) begin
          rdata_q <= mem_q[mem_axi_araddr[IDX_W+1:2]];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  logic        aw_held_q, aw_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        cons_valid_q, cons_valid_d;
  logic [7:0]  cons_data_q, cons_data_d;
  logic        aw_hs, w_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ram, wr_cons;

  assign mem_axi_awready = resetn && !aw_held_q && !bvalid_q;
  assign mem_axi_wready  = resetn && !w_held_q && !bvalid_q;
  assign aw_hs           = mem_axi_awvalid && mem_axi_awready;
  assign w_hs            = mem_axi_wvalid && mem_axi_wready;
  assign commit          = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // A held beat wins over the bus, because the bus side is not ready while held.
  assign wr_addr = aw_held_q ? awaddr_q : mem_axi_awaddr;
  assign wr_data = w_held_q  ? wdata_q  : mem_axi_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : mem_axi_wstrb;
  assign wr_ram  = is_ram(wr_addr);
  assign wr_cons = !wr_ram && is_console(wr_addr);

  assign mem_axi_bvalid = bvalid_q;
  assign mem_axi_bresp  = bresp_q;
  assign console_valid  = cons_valid_q;
  assign console_data   = cons_data_q;

  always_comb begin
    aw_held_d    = commit ? 1'b0 : (aw_held_q || aw_hs);
    awaddr_d     = aw_hs ? mem_axi_awaddr : awaddr_q;
    w_held_d     = commit ? 1'b0 : (w_held_q || w_hs);
    wdata_d      = w_hs ? mem_axi_wdata : wdata_q;
    wstrb_d      = w_hs ? mem_axi_wstrb : wstrb_q;
    bvalid_d     = commit || (bvalid_q && !mem_axi_bready);
    bresp_d      = bresp_q;
    cons_valid_d = commit && wr_cons;
    cons_data_d  = cons_data_q;
    if (commit) begin
      bresp_d = (wr_ram || wr_cons) ? RESP_OKAY : RESP_SLVERR;
      if (wr_cons) cons_data_d = wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held_q    <= 1'b0;
      awaddr_q     <= '0;
      w_held_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      cons_valid_q <= 1'b0;
      cons_data_q  <= '0;
    end else begin
      aw_held_q    <= aw_held_d;
      awaddr_q     <= awaddr_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
    end
  end

  // SRAM has no reset so its contents survive resetn. The resetn term blocks a
  // commit from beats that were held when reset arrived.
  always_ff @(posedge clk) begin
    if (resetn && commit && wr_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem_q[wr_addr[IDX_W+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
module tb_axi4lite_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        console_valid;
  logic [7:0]  console_data;

  int total = 0;
  int bad   = 0;
  int cons_cnt = 0;
  logic [7:0] cons_seen = '0;

  always #5 clk = ~clk;

  axi4lite_sram_slave dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_axi_awvalid (awvalid),
    .mem_axi_awready (awready),
    .mem_axi_awaddr  (awaddr),
    .mem_axi_awprot  (3'b000),
    .mem_axi_wvalid  (wvalid),
    .mem_axi_wready  (wready),
    .mem_axi_wdata   (wdata),
    .mem_axi_wstrb   (wstrb),
    .mem_axi_bvalid  (bvalid),
    .mem_axi_bready  (bready),
    .mem_axi_bresp   (bresp),
    .mem_axi_arvalid (arvalid),
    .mem_axi_arready (arready),
    .mem_axi_araddr  (araddr),
    .mem_axi_arprot  (3'b000),
    .mem_axi_rvalid  (rvalid),
    .mem_axi_rready  (rready),
    .mem_axi_rdata   (rdata),
    .mem_axi_rresp   (rresp),
    .console_valid   (console_valid),
    .console_data    (console_data)
  );

  always @(negedge clk) begin
    if (console_valid) begin
      cons_cnt  = cons_cnt + 1;
      cons_seen = console_data;
    end
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   n;
    logic aw_go, w_go;
    n = 0;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    chk("wr_handshake_timeout", 32'(n >= 20), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid_at_commit", 32'(bvalid), 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    chk("wr_bvalid_release", 32'(bvalid), 32'd0);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; rready = 1'b0;
    while (!arready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_arready_timeout", 32'(n >= 20), 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_rvalid_latency", 32'(rvalid), 32'd1);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rd_rvalid_release", 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  logic [1:0]  resp_v;
  logic [31:0] rd_v;
  int          cnt0;

  initial begin
    resetn = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;

    vecs[0]  = mk(1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 2'b00, 32'h0);
    vecs[1]  = mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0);
    vecs[2]  = mk(1'b0, 32'h0000_0100, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF);
    vecs[3]  = mk(1'b1, 32'h0000_0100, 32'h0000_00AA, 4'h1, 2'b00, 32'h0);
    vecs[4]  = mk(1'b0, 32'h0000_0100, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEAA);
    vecs[5]  = mk(1'b0, 32'h0000_0102, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEAA);
    vecs[6]  = mk(1'b1, 32'h0000_0104, 32'h1234_5678, 4'hF, 2'b00, 32'h0);
    vecs[7]  = mk(1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'h6, 2'b00, 32'h0);
    vecs[8]  = mk(1'b0, 32'h0000_0104, 32'h0,         4'h0, 2'b00, 32'h12BB_CC78);
    vecs[9]  = mk(1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0);
    vecs[10] = mk(1'b0, 32'h0000_0104, 32'h0,         4'h0, 2'b00, 32'h12BB_CC78);
    vecs[11] = mk(1'b1, 32'h0002_0000, 32'h5555_5555, 4'hF, 2'b10, 32'h0);
    vecs[12] = mk(1'b0, 32'h2000_0000, 32'h0,         4'h0, 2'b10, 32'h0);
    vecs[13] = mk(1'b0, 32'h1000_0000, 32'h0,         4'h0, 2'b10, 32'h0);
    vecs[14] = mk(1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1122_3344);
    vecs[15] = mk(1'b1, 32'h0000_FFFC, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0);
    vecs[16] = mk(1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 2'b00, 32'h0BAD_F00D);
    vecs[17] = mk(1'b1, 32'h0001_0000, 32'h7777_7777, 4'hF, 2'b10, 32'h0);
    vecs[18] = mk(1'b0, 32'h0001_0000, 32'h0,         4'h0, 2'b10, 32'h0);
    vecs[19] = mk(1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1122_3344);

    // Outputs while held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_console_valid", 32'(console_valid), 32'd0);
    chk("rst_console_data",  32'(console_data),  32'd0);
    resetn = 1'b1;
    #1;
    chk("rel_arready", 32'(arready), 32'd1);
    chk("rel_awready", 32'(awready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp_v);
        chk($sformatf("v%0d_bresp", i), 32'(resp_v), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, rd_v, resp_v);
        chk($sformatf("v%0d_rdata", i), rd_v, vecs[i].rdata);
        chk($sformatf("v%0d_rresp", i), 32'(resp_v), 32'(vecs[i].resp));
      end
    end

    // Console write: single pulse, low byte only, strobes ignored, RAM untouched.
    cnt0 = cons_cnt;
    axi_write(32'h1000_0000, 32'h1234_5641, 4'h0, resp_v);
    chk("cons_bresp", 32'(resp_v), 32'd0);
    repeat (3) @(negedge clk);
    chk("cons_pulse_count", 32'(cons_cnt - cnt0), 32'd1);
    chk("cons_data", 32'(cons_seen), 32'h41);
    axi_read(32'h0000_0000, rd_v, resp_v);
    chk("cons_ram_unchanged", rd_v, 32'h1122_3344);

    // W three cycles ahead of AW, response stalled four cycles.
    @(negedge clk);
    bready = 1'b0; wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    chk("stall_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) begin
      chk("stall_no_bvalid",  32'(bvalid),  32'd0);
      chk("stall_w_held",     32'(wready),  32'd0);
      chk("stall_aw_open",    32'(awready), 32'd1);
      @(posedge clk); #1;
    end
    awvalid = 1'b1; awaddr = 32'h0000_0200;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("stall_bvalid_commit", 32'(bvalid), 32'd1);
    chk("stall_bresp_commit",  32'(bresp),  32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_bvalid_hold", 32'(bvalid),  32'd1);
      chk("stall_bresp_hold",  32'(bresp),   32'd0);
      chk("stall_awready_low", 32'(awready), 32'd0);
      chk("stall_wready_low",  32'(wready),  32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("stall_bvalid_drop", 32'(bvalid),  32'd0);
    chk("stall_awready_back", 32'(awready), 32'd1);
    axi_read(32'h0000_0200, rd_v, resp_v);
    chk("stall_readback", rd_v, 32'hCAFE_F00D);

    // Read and write to the same word on the same edge.
    axi_write(32'h0000_0300, 32'h0102_0304, 4'hF, resp_v);
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0000_0300;
    awvalid = 1'b1; awaddr = 32'h0000_0300;
    wvalid  = 1'b1; wdata  = 32'h0A0B_0C0D; wstrb = 4'hF;
    rready = 1'b0; bready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_rdata_old", rdata, 32'h0102_0304);
    chk("same_bvalid", 32'(bvalid), 32'd1);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    chk("same_rvalid_drop", 32'(rvalid), 32'd0);
    chk("same_bvalid_drop", 32'(bvalid), 32'd0);
    axi_read(32'h0000_0300, rd_v, resp_v);
    chk("same_readback_new", rd_v, 32'h0A0B_0C0D);

    // Reset with a read response pending and an address held.
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0000_0100;
    awvalid = 1'b1; awaddr = 32'h0000_0400;
    rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    chk("mid_rvalid", 32'(rvalid), 32'd1);
    chk("mid_aw_held", 32'(awready), 32'd0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rdata",  rdata,       32'd0);
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_console_data", 32'(console_data), 32'd0);
    resetn = 1'b1;
    #1;
    chk("mid_rel_awready", 32'(awready), 32'd1);
    wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_no_stale_commit", 32'(bvalid), 32'd0);
    awvalid = 1'b1; awaddr = 32'h0000_0404;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("mid_commit_bvalid", 32'(bvalid), 32'd1);
    chk("mid_commit_bresp",  32'(bresp),  32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(32'h0000_0404, rd_v, resp_v);
    chk("mid_readback_404", rd_v, 32'h5A5A_5A5A);
    axi_read(32'h0000_0100, rd_v, resp_v);
    chk("mid_sram_preserved", rd_v, 32'hDEAD_BEAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
